// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first through one
// full-subtractor slice, returning {borrow, difference} after WIDTH cycles.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   o,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             borrow_reg, borrow_next;
  logic [CW-1:0]    count_reg, count_next;

  logic             diff_bit;
  logic             borrow_bit;
  logic             last_bit;
  logic [WIDTH-1:0] result_shift;

  // Full-subtractor slice on the operand LSBs and the running borrow.
  assign diff_bit   = a_reg[0] ^ b_reg[0] ^ borrow_reg;
  assign borrow_bit = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow_reg);
  assign last_bit   = (count_reg == CW'(WIDTH - 1));

  // New difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_one
      assign result_shift = diff_bit;
    end else begin : g_res_wide
      assign result_shift = {diff_bit, result_reg[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    result_next = result_reg;
    borrow_next = borrow_reg;
    count_next  = count_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next      = a;
          b_next      = b;
          borrow_next = 1'b0;
          count_next  = '0;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        a_next      = a_reg >> 1;
        b_next      = b_reg >> 1;
        result_next = result_shift;
        borrow_next = borrow_bit;
        count_next  = count_reg + CW'(1);
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      borrow_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      result_reg <= result_next;
      borrow_reg <= borrow_next;
      count_reg  <= count_next;
    end
  end

  // Status is decoded from the state register; rst only masks acceptance.
  assign in_ready  = (state_reg == IDLE) & ~rst;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == SHIFT) | (state_reg == DONE);
  assign o         = {borrow_reg, result_reg};

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor; the inverse of the team's ripple-carry adder datapath. Accepts two WIDTH-bit operands over a valid/ready handshake and computes a − b one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It returns {borrow_out, difference} in the same WIDTH+1-bit layout the adder uses for {carry_out, sum}. It trades WIDTH cycles of latency for one-bit-slice area in the arithmetic datapath.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥ 1.

- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands; high only in IDLE and not in reset.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  result on o is valid.
- out_ready  input  1  consumer accepts result.
- o  output  WIDTH+1  o[WIDTH] = borrow (1 iff a < b); o[WIDTH-1:0] = (a − b) mod 2^WIDTH.
- busy  output  1  high in SHIFT or DONE.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid at a rising edge, capture a and b into shift registers, clear borrow, clear counter, and go to SHIFT.
  - SHIFT: each cycle, with a0/b0 as the shift-register LSBs and br as the borrow register:
    - d = a0 ^ b0 ^ br
    - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
    - shift d into the result register from the MSB side (right shift); shift both operand registers right; increment the counter.
    - After the WIDTH-th bit, go to DONE.
  - DONE: out_valid=1 and o = {br, result}, held stable. On out_ready at an edge, go to IDLE.
- Counter width is clog2(WIDTH+1). The SHIFT→DONE transition occurs on the edge where count reaches WIDTH.
- a and b are sampled only at the input handshake. Later changes on a or b have no effect.
- in_valid outside IDLE is ignored; no queuing.
- o reflects internal registers at all times. It is only meaningful while out_valid=1.
- Reset (asynchronous, any state):
  - state becomes IDLE; shift registers, borrow, counter and result are cleared.
  - out_valid=0, busy=0, o=0, in_ready=0 while rst is high.
  - An operation in flight when reset asserts is abandoned and produces no output.

## Timing
- Input handshake at edge T → state is SHIFT after T.
- Bit i (LSB = 0) is processed at edge T+1+i.
- DONE after edge T+WIDTH, so out_valid is high in the cycle following edge T+WIDTH. Latency is WIDTH cycles.
- Output handshake at the first edge with out_valid & out_ready. With out_ready held high, that is edge T+WIDTH+1.
- IDLE after the output handshake; the earliest next acceptance is edge T+WIDTH+2. Sustained throughput is one result per WIDTH+2 cycles.
- in_ready deasserts in the cycle after acceptance. out_valid deasserts in the cycle after the output handshake.
- in_ready, out_valid and busy are decoded from registered state; no combinational input→output path.
- Backpressure: DONE holds indefinitely while out_ready=0; o does not change.
- rst deassertion: first acceptance is possible at the first rising edge with rst low.

## Test plan
- WIDTH=8, a=5, b=3 → out_valid 8 cycles after acceptance, o=9'h002.
- WIDTH=8, a=3, b=5 → o=9'h1FE. Then a=0, b=255 → o=9'h101. Then a=255, b=255 → o=9'h000. Then a=0, b=0 → o=9'h000.
- Backpressure:
  - stimulus: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with new operands.
  - response: o stable, in_ready=0, no new capture; exactly one result transfers when out_ready rises.
- Reset mid-operation:
  - stimulus: accept a=200, b=100, assert rst at bit 4, release, then accept a=7, b=9.
  - response: no output for the first operation; o=0 and out_valid=0 during reset; second result o=9'h1FE.
- Back-to-back with out_ready tied high: 1000 random operand pairs at WIDTH=8 versus the model {a<b, (a−b) mod 256}. Accept spacing is exactly 10 cycles.
- Parameter sweep over WIDTH=1, 3, 16 with random operands against the same model. For WIDTH=1, a=0, b=1 → o=2'b11.
